// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared playfield geometry, map type, line-clear FSM state
//               encoding and the per-landing score table.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = 3;   // row index width
  localparam int CNT_W = 3;   // per-landing cleared-row counter width

  // Row index first; row 0 is the top row, column 0 is the leftmost bit.
  typedef logic [0:ROWS-1][0:COLS-1] map_t;

  typedef enum logic [1:0] {
    LC_IDLE  = 2'd0,
    LC_SCAN  = 2'd1,
    LC_CLEAR = 2'd2,
    LC_SCORE = 2'd3
  } lc_state_t;

  // Points awarded for the number of rows cleared by a single landing.
  function automatic logic [3:0] points_for(input logic [CNT_W-1:0] cnt);
    logic [3:0] pts;
    case (cnt)
      3'd0:    pts = 4'd0;
      3'd1:    pts = 4'd1;
      3'd2:    pts = 4'd3;
      3'd3:    pts = 4'd5;
      default: pts = 4'd8;
    endcase
    return pts;
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_row_finder.sv
`default_nettype none
// ============================================================================
// Module      : full_row_finder
// Description : Combinational search of the playfield map for the lowest
//               (highest-index) completely filled row. Row 0 is excluded
//               from the search because it is never cleared; instead its
//               occupancy is reported as top_occupied.
// Ports       : map_in       - playfield map
//               found        - at least one of rows ROWS-1..1 is full
//               row          - index of the highest-index full row
//               top_occupied - any cell of row 0 is set
// Revision    : 1.0 - initial release
// ============================================================================
module full_row_finder
  import tetris_pkg::*;
(
  input  map_t             map_in,
  output logic             found,
  output logic [ROW_W-1:0] row,
  output logic             top_occupied
);

  logic [ROWS-1:1] row_full;

  genvar g;
  generate
    for (g = 1; g < ROWS; g++) begin : g_row
      assign row_full[g] = &map_in[g];
    end
  endgenerate

  // Ascending walk: the last hit wins, giving priority to the highest index.
  always_comb begin
    found = 1'b0;
    row   = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (row_full[r]) begin
        found = 1'b1;
        row   = ROW_W'(r);
      end
    end
  end

  assign top_occupied = |map_in[0];

endmodule
`default_nettype wire

// File: rtl/line_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_ctrl
// Description : After each block landing, repeatedly finds and clears full
//               rows (one per CLEAR cycle), then awards score, updates the
//               line counters and raises the sticky game-over flag.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               map_in       - committed playfield map
//               land         - block merged into the map at this edge
//               remove_line  - one-hot row-shift command (row 0 never set)
//               busy         - controller not idle
//               done         - one-cycle pulse when a landing is finished
//               lines_last   - rows cleared by the latest landing
//               lines_total  - rows cleared since reset (saturating)
//               score        - accumulated score (saturating)
//               game_over    - sticky, set when row 0 is occupied at scoring
// Revision    : 1.0 - initial release
// ============================================================================
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  map_t               map_in,
  input  logic               land,
  output logic [ROWS-1:0]    remove_line,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   lines_last,
  output logic [7:0]         lines_total,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  lc_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0]    remove_line_q, remove_line_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   lines_last_q, lines_last_d;
  logic [7:0]         lines_total_q, lines_total_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               game_over_q, game_over_d;

  logic               found;
  logic [ROW_W-1:0]   found_row;
  logic               top_occupied;

  logic [SCORE_W:0]   score_sum;
  logic [8:0]         total_sum;

  full_row_finder u_finder (
    .map_in       (map_in),
    .found        (found),
    .row          (found_row),
    .top_occupied (top_occupied)
  );

  // One extra bit on each sum exposes the carry used for saturation.
  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(points_for(cnt_q));
  assign total_sum = {1'b0, lines_total_q} + 9'(cnt_q);

  // Scoring results are registered on the SCAN->SCORE transition so they are
  // already valid in the cycle where done pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    remove_line_d = '0;
    done_d        = 1'b0;
    lines_last_d  = lines_last_q;
    lines_total_d = lines_total_q;
    score_d       = score_q;
    game_over_d   = game_over_q;

    case (state_q)
      LC_IDLE: begin
        if (land && !game_over_q) begin
          state_d = LC_SCAN;
          cnt_d   = '0;
        end
      end
      LC_SCAN: begin
        if (found) begin
          state_d       = LC_CLEAR;
          remove_line_d = ROWS'(1) << found_row;
          cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end else begin
          state_d       = LC_SCORE;
          done_d        = 1'b1;
          lines_last_d  = cnt_q;
          lines_total_d = total_sum[8] ? 8'hFF : total_sum[7:0];
          score_d       = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          if (top_occupied) begin
            game_over_d = 1'b1;
          end
        end
      end
      // Rows have moved down on the closing edge; rescan from the bottom.
      LC_CLEAR: state_d = LC_SCAN;
      LC_SCORE: state_d = LC_IDLE;
      default:  state_d = LC_IDLE;
    endcase

    busy_d = (state_d != LC_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LC_IDLE;
      cnt_q         <= '0;
      remove_line_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      lines_last_q  <= '0;
      lines_total_q <= '0;
      score_q       <= '0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      remove_line_q <= remove_line_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      lines_last_q  <= lines_last_d;
      lines_total_q <= lines_total_d;
      score_q       <= score_d;
      game_over_q   <= game_over_d;
    end
  end

  assign remove_line = remove_line_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign lines_last  = lines_last_q;
  assign lines_total = lines_total_q;
  assign score       = score_q;
  assign game_over   = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_clear_ctrl
// Description : Self-checking bench for line_clear_ctrl with an ideal
//               shifting colour-map model in the loop.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  typedef struct {
    map_t            map;
    int              k;     // rows expected to be cleared
    logic [7:0][7:0] rm;    // expected remove_line sequence
    int              pts;   // points for this landing
    int              go;    // landing ends the game
  } vec_t;

  typedef struct {
    int              lat;
    int              lines;
    int              score;
    int              total;
    int              go;
    int              nrm;
    logic [7:0][7:0] rm;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            land = 1'b0;
  logic            load_req = 1'b0;
  map_t            load_map = '0;
  map_t            pf_map = '0;
  logic [ROWS-1:0] remove_line;
  logic            busy, done, game_over;
  logic [2:0]      lines_last;
  logic [7:0]      lines_total;
  logic [15:0]     score;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int land_cyc = 0;
  int sc_m = 0;
  int tot_m = 0;
  int go_m = 0;
  exp_t       sb[$];
  logic [7:0] rm_log[$];
  vec_t       vecs[7];

  line_clear_ctrl #(.SCORE_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .map_in      (pf_map),
    .land        (land),
    .remove_line (remove_line),
    .busy        (busy),
    .done        (done),
    .lines_last  (lines_last),
    .lines_total (lines_total),
    .score       (score),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Colour-map model: merges a landed block on the land edge, shifts rows
  // above a removed row down by one, row 0 becomes empty.
  always @(posedge clk) begin
    if (load_req) begin
      pf_map <= load_map;
    end else if (remove_line != '0) begin
      for (int r = 1; r < ROWS; r++) begin
        if (remove_line[r]) begin
          for (int i = 1; i <= r; i++) pf_map[i] <= pf_map[i-1];
          pf_map[0] <= '0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor / scoreboard consumer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rm_log.delete();
      end else begin
        if (land) begin
          land_cyc = cyc;
          check("land_remove_overlap", 32'(remove_line), 32'd0);
        end
        if (remove_line != '0) begin
          check("rm_row0_clear", 32'(remove_line[0]), 32'd0);
          rm_log.push_back(remove_line);
        end
        if (done) begin
          check("done_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done_latency", 32'(cyc - land_cyc), 32'(e.lat));
            check("busy_at_done", 32'(busy), 32'd1);
            check("lines_last", 32'(lines_last), 32'(e.lines));
            check("score", 32'(score), 32'(e.score));
            check("lines_total", 32'(lines_total), 32'(e.total));
            check("game_over", 32'(game_over), 32'(e.go));
            check("rm_count", 32'(rm_log.size()), 32'(e.nrm));
            for (int j = 0; j < rm_log.size() && j < e.nrm; j++)
              check("rm_seq", 32'(rm_log[j]), 32'(e.rm[j]));
          end
          rm_log.delete();
        end
      end
    end
  end

  task automatic do_landing(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    load_map = v.map;
    load_req = 1'b1;
    land     = 1'b1;
    sc_m  = (sc_m + v.pts > 65535) ? 65535 : sc_m + v.pts;
    tot_m = (tot_m + v.k > 255) ? 255 : tot_m + v.k;
    if (v.go != 0) go_m = 1;
    e.lat   = 2 + 2 * v.k;
    e.lines = v.k;
    e.score = sc_m;
    e.total = tot_m;
    e.go    = go_m;
    e.nrm   = v.k;
    e.rm    = v.rm;
    sb.push_back(e);
    @(posedge clk); #1;
    land     = 1'b0;
    load_req = 1'b0;
    @(negedge clk);
    check("busy_cycle1", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   seen;

    for (int i = 0; i < 7; i++) begin
      vecs[i].map = '0;
      vecs[i].rm  = '0;
      vecs[i].k   = 0;
      vecs[i].pts = 0;
      vecs[i].go  = 0;
    end
    // 1: bottom row full, sparse rows above
    vecs[1].map[7] = 8'hFF; vecs[1].map[6] = 8'h81; vecs[1].map[5] = 8'h42;
    vecs[1].map[4] = 8'h24; vecs[1].map[3] = 8'h18; vecs[1].map[2] = 8'h3C;
    vecs[1].map[1] = 8'h7E;
    vecs[1].k = 1; vecs[1].pts = 1; vecs[1].rm[0] = 8'h80;
    // 2: rows 5..7 full
    vecs[2].map[7] = 8'hFF; vecs[2].map[6] = 8'hFF; vecs[2].map[5] = 8'hFF;
    vecs[2].map[4] = 8'h01;
    vecs[2].k = 3; vecs[2].pts = 5;
    vecs[2].rm[0] = 8'h80; vecs[2].rm[1] = 8'h80; vecs[2].rm[2] = 8'h80;
    // 3: rows 7 and 4 full, 5/6 partial
    vecs[3].map[7] = 8'hFF; vecs[3].map[6] = 8'hF0; vecs[3].map[5] = 8'h0F;
    vecs[3].map[4] = 8'hFF; vecs[3].map[3] = 8'h11;
    vecs[3].k = 2; vecs[3].pts = 3; vecs[3].rm[0] = 8'h80; vecs[3].rm[1] = 8'h20;
    // 4: five full rows -> top of the points table
    for (int r = 3; r < 8; r++) vecs[4].map[r] = 8'hFF;
    vecs[4].map[2] = 8'h02;
    vecs[4].k = 5; vecs[4].pts = 8;
    for (int j = 0; j < 5; j++) vecs[4].rm[j] = 8'h80;
    // 5: only row 1 full (uppermost clearable row)
    vecs[5].map[1] = 8'hFF; vecs[5].map[2] = 8'h01;
    vecs[5].k = 1; vecs[5].pts = 1; vecs[5].rm[0] = 8'h02;
    // 6: row 0 occupied -> game over
    vecs[6].map[0] = 8'h10; vecs[6].go = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_remove_line", 32'(remove_line), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_lines_total", 32'(lines_total), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) do_landing(vecs[i]);

    // Landing after game over is ignored.
    @(posedge clk); #1;
    load_map = '0; load_req = 1'b1; land = 1'b1;
    @(posedge clk); #1;
    land = 1'b0; load_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("go_ignored_busy", 32'(busy), 32'd0);
      check("go_ignored_done", 32'(done), 32'd0);
    end
    check("go_sticky", 32'(game_over), 32'd1);

    // Reset, score one row, then abort a clear with reset.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    sc_m = 0; tot_m = 0; go_m = 0;
    check("rst2_game_over", 32'(game_over), 32'd0);
    v = vecs[1];
    do_landing(v);

    @(posedge clk); #1;
    load_map = '0; load_map[7] = 8'hFF; load_map[6] = 8'hFF;
    load_req = 1'b1; land = 1'b1;
    @(posedge clk); #1;
    land = 1'b0; load_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (remove_line != '0) seen = 1;
    end
    check("abort_clear_seen", 32'(seen), 32'd1);
    check("abort_pre_score", 32'(score), 32'd1);
    reset = 1'b1;             // sampled at the closing edge of CLEAR
    @(negedge clk);
    check("abort_remove_line", 32'(remove_line), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_score", 32'(score), 32'd0);
    check("abort_game_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
